alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares the execute-stage ALU between two requesters, e.g. the main pipeline (port 0) and an address/branch-compare helper (port 1). It arbitrates round-robin, issues one operation per cycle to an internally instantiated ALU, and registers the result into a one-entry output stage. The registered result goes back only to the requester that issued the operation, over a valid/ready handshake. The block owns all sequencing; requesters see a one-cycle-latency ALU service.

## Interface
- DATA_WIDTH, 32, operand/result width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Req0Valid / Req1Valid  in  1  request present
- Req0Ready / Req1Ready  out  1  request accepted this cycle when Valid && Ready
- Req0Control / Req1Control  in  4  ALU operation: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001
- Req0SrcA, Req0SrcB / Req1SrcA, Req1SrcB  in  DATA_WIDTH  operands
- Resp0Valid / Resp1Valid  out  1  result available for that requester
- Resp0Ready / Resp1Ready  in  1  requester consumes result
- RespResult  out  DATA_WIDTH  registered ALU result (shared bus, qualified by RespNValid)
- RespZero  out  1  RespResult == 0
- RespNegative  out  1  RespResult[DATA_WIDTH-1]

## Operation
- State:
  - `OutValid` (1b): output stage full.
  - `OutOwner` (1b): which requester owns the held result.
  - `LastGrant` (1b): requester most recently accepted.
  - Output registers: result, zero, negative.
- Drain condition: `Drain = OutValid && RespReady[OutOwner]`.
- Issue opportunity: `CanIssue = !OutValid || Drain`. A new accept is allowed in the same cycle the held result drains.
- Arbitration, only when CanIssue:
  - Only one requester valid: grant it.
  - Both valid: grant `!LastGrant`.
  - Neither valid: no grant.
- `ReqNReady = CanIssue && grantN`. At most one Ready is high per cycle.
- Ready may depend combinationally on Valid; requesters must not make Valid depend on Ready.
- On accept, the granted operands and control drive the ALU. On the same edge:
  - ALU outputs load into the output registers.
  - `OutOwner` and `LastGrant` load the grant index.
  - `OutValid` is set to 1.
- On a drain without a new accept, `OutValid` clears. Output data registers hold their last value.
- `RespNValid = OutValid && (OutOwner == N)`.
- ALU semantics:
  - Shift amount is SrcB[4:0] (SrcB[$clog2(DATA_WIDTH)-1:0] in general).
  - SRA sign-extends from SrcA's MSB.
  - SLT compares signed; SLTU compares unsigned.
  - Undefined control codes yield result 0, with zero = 1 and negative = 0.
  - Add and sub wrap modulo 2^DATA_WIDTH.
- Fairness: a continuously valid requester is accepted within 2 consecutive issue opportunities.

## Timing
- Reset, async assert: `OutValid` = 0, `OutOwner` = 0, `LastGrant` = 1 (port 0 wins the first tie), output data regs = 0. All Ready/Valid outputs are low while rst is high.
- Latency: accept at edge N gives RespNValid high from N+1. It stays high, with result and flags stable, until the cycle where RespNReady = 1.
- Throughput: 1 op/cycle when the owner holds RespReady high.
- Backpressure: while the held result is undrained, both ReqReady are 0.
- A RespReady on the non-owner port is ignored.
- Reset mid-operation: any pending result is discarded and no response is produced for it after reset deasserts.
- First accept is possible in the cycle after rst deasserts.

## Test plan
- Single request: Req0 ADD 5+7, Resp0Ready=1. Expect Req0Ready=1 that cycle; next cycle Resp0Valid=1, RespResult=12, zero=0, negative=0; Resp1Valid stays 0.
- Contention: both valid every cycle, both RespReady=1. Expect accept order 0,1,0,1,… with one result per cycle, each on the matching RespN port.
- Backpressure: Req1 SUB 0-1 accepted, Resp1Ready held 0 for 3 cycles while Req0Valid=1.
  - During the stall: Result = 0xFFFFFFFF, negative=1, held stable; Req0Ready=0.
  - When Resp1Ready rises: Req0 is accepted in the same cycle.
- Flags and ops:
  - SUB 3-3 gives 0 with zero=1.
  - SRA 0x80000000>>4 gives 0xF8000000.
  - SLT 0xFFFFFFFF vs 1 gives 1; SLTU of the same operands gives 0.
  - Control 1111 gives 0 with zero=1.
- Reset mid-operation: accept Req0 ADD, assert rst before Resp0Ready.
  - Expect all Valid/Ready low immediately.
  - After release: no stale response; the next tie goes to port 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end for a shared execute-stage ALU with a
// one-entry registered result stage returned to the issuing requester.

module alu_share_arbiter_alu #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [3:0]            i_control,
  input  logic [DATA_WIDTH-1:0] i_src_a,
  input  logic [DATA_WIDTH-1:0] i_src_b,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_zero,
  output logic                  o_negative
);
  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } op_e;

  logic [SHW-1:0] w_shamt;
  op_e            w_op;

  assign w_shamt = i_src_b[SHW-1:0];
  assign w_op    = op_e'(i_control);

  always_comb begin
    o_result = '0;
    case (w_op)
      OP_ADD:  o_result = i_src_a + i_src_b;
      OP_SUB:  o_result = i_src_a - i_src_b;
      OP_AND:  o_result = i_src_a & i_src_b;
      OP_OR:   o_result = i_src_a | i_src_b;
      OP_XOR:  o_result = i_src_a ^ i_src_b;
      OP_SLL:  o_result = i_src_a << w_shamt;
      OP_SRL:  o_result = i_src_a >> w_shamt;
      OP_SRA:  o_result = $signed(i_src_a) >>> w_shamt;
      OP_SLT:  o_result = {{(DATA_WIDTH-1){1'b0}}, $signed(i_src_a) < $signed(i_src_b)};
      OP_SLTU: o_result = {{(DATA_WIDTH-1){1'b0}}, i_src_a < i_src_b};
      default: o_result = '0;
    endcase
  end

  assign o_zero     = (o_result == '0);
  assign o_negative = o_result[DATA_WIDTH-1];
endmodule

module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Req0Valid,
  output logic                  Req0Ready,
  input  logic [3:0]            Req0Control,
  input  logic [DATA_WIDTH-1:0] Req0SrcA,
  input  logic [DATA_WIDTH-1:0] Req0SrcB,
  input  logic                  Req1Valid,
  output logic                  Req1Ready,
  input  logic [3:0]            Req1Control,
  input  logic [DATA_WIDTH-1:0] Req1SrcA,
  input  logic [DATA_WIDTH-1:0] Req1SrcB,
  output logic                  Resp0Valid,
  input  logic                  Resp0Ready,
  output logic                  Resp1Valid,
  input  logic                  Resp1Ready,
  output logic [DATA_WIDTH-1:0] RespResult,
  output logic                  RespZero,
  output logic                  RespNegative
);
  logic                  r_out_valid;
  logic                  r_out_owner;
  logic                  r_last_grant;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_negative;

  logic                  w_drain;
  logic                  w_can_issue;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_accept;
  logic [3:0]            w_control;
  logic [DATA_WIDTH-1:0] w_src_a;
  logic [DATA_WIDTH-1:0] w_src_b;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_alu_zero;
  logic                  w_alu_negative;

  assign w_drain = r_out_valid && (r_out_owner ? Resp1Ready : Resp0Ready);

  // rst gates issue so Ready stays low while reset is held, even with Valid up
  assign w_can_issue = !rst && (!r_out_valid || w_drain);

  assign w_grant0 = Req0Valid && (!Req1Valid || r_last_grant);
  assign w_grant1 = Req1Valid && (!Req0Valid || !r_last_grant);
  assign w_accept = w_can_issue && (w_grant0 || w_grant1);

  assign Req0Ready = w_can_issue && w_grant0;
  assign Req1Ready = w_can_issue && w_grant1;

  assign w_control = w_grant1 ? Req1Control : Req0Control;
  assign w_src_a   = w_grant1 ? Req1SrcA    : Req0SrcA;
  assign w_src_b   = w_grant1 ? Req1SrcB    : Req0SrcB;

  alu_share_arbiter_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .i_control  (w_control),
    .i_src_a    (w_src_a),
    .i_src_b    (w_src_b),
    .o_result   (w_alu_result),
    .o_zero     (w_alu_zero),
    .o_negative (w_alu_negative)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_owner  <= 1'b0;
      r_last_grant <= 1'b1;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_negative   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_owner  <= w_grant1;
      r_last_grant <= w_grant1;
      r_result     <= w_alu_result;
      r_zero       <= w_alu_zero;
      r_negative   <= w_alu_negative;
    end else if (w_drain) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign Resp0Valid   = r_out_valid && !r_out_owner;
  assign Resp1Valid   = r_out_valid &&  r_out_owner;
  assign RespResult   = r_result;
  assign RespZero     = r_zero;
  assign RespNegative = r_negative;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a transaction-level model checked every
// cycle, plus hand-computed literal expectations on key cycles.

module tb_alu_share_arbiter;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          Req0Valid, Req1Valid, Req0Ready, Req1Ready;
  logic [3:0]    Req0Control, Req1Control;
  logic [DW-1:0] Req0SrcA, Req0SrcB, Req1SrcA, Req1SrcB;
  logic          Resp0Valid, Resp1Valid, Resp0Ready, Resp1Ready;
  logic [DW-1:0] RespResult;
  logic          RespZero, RespNegative;

  alu_share_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Control(Req0Control),
    .Req0SrcA(Req0SrcA), .Req0SrcB(Req0SrcB),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Control(Req1Control),
    .Req1SrcA(Req1SrcA), .Req1SrcB(Req1SrcB),
    .Resp0Valid(Resp0Valid), .Resp0Ready(Resp0Ready),
    .Resp1Valid(Resp1Valid), .Resp1Ready(Resp1Ready),
    .RespResult(RespResult), .RespZero(RespZero), .RespNegative(RespNegative)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Literal expectations posted by the stimulus for the current cycle:
  // lit_hs = {Req0Ready, Req1Ready, Resp0Valid, Resp1Valid}
  logic          lit_hs_en = 1'b0, lit_data_en = 1'b0;
  logic [3:0]    lit_hs;
  logic [DW-1:0] lit_res;
  logic          lit_z, lit_n;

  // Model of the held response: one slot, its owner, its value, and who was last served
  logic          m_full, m_owner, m_last;
  logic [DW-1:0] m_res;
  logic          n_full, n_owner, n_last;
  logic [DW-1:0] n_res;

  function automatic logic [DW-1:0] alu(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int unsigned sh;
    sh = b % DW;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return DW'($signed(a) >>> sh);
      4'd8: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      4'd9: return (a < b) ? DW'(1) : DW'(0);
      default: return '0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_full = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_res = '0;
    end else begin
      m_full = n_full; m_owner = n_owner; m_last = n_last; m_res = n_res;
    end
  end

  always @(negedge clk) begin
    logic exp_r0, exp_r1, exp_v0, exp_v1, slot_free, winner, any;
    exp_r0 = 1'b0; exp_r1 = 1'b0; winner = 1'b0;
    exp_v0 = !rst && m_full && (m_owner == 1'b0);
    exp_v1 = !rst && m_full && (m_owner == 1'b1);
    n_full = m_full; n_owner = m_owner; n_last = m_last; n_res = m_res;
    if (rst) begin
      n_full = 1'b0; n_owner = 1'b0; n_last = 1'b1; n_res = '0;
    end else begin
      slot_free = !m_full || (m_owner ? Resp1Ready : Resp0Ready);
      any = Req0Valid || Req1Valid;
      if (Req0Valid && Req1Valid) winner = (m_last == 1'b0);
      else                        winner = Req1Valid;
      if (slot_free && any) begin
        exp_r0 = (winner == 1'b0);
        exp_r1 = (winner == 1'b1);
        n_full = 1'b1; n_owner = winner; n_last = winner;
        n_res  = winner ? alu(Req1Control, Req1SrcA, Req1SrcB)
                        : alu(Req0Control, Req0SrcA, Req0SrcB);
      end else if (slot_free) begin
        n_full = 1'b0;
      end
    end

    tests++;
    if ({Req0Ready, Req1Ready, Resp0Valid, Resp1Valid} !== {exp_r0, exp_r1, exp_v0, exp_v1}) begin
      fails++;
      $display("FAIL model_handshake t=%0t got r0r1v0v1=%b%b%b%b want %b%b%b%b", $time,
               Req0Ready, Req1Ready, Resp0Valid, Resp1Valid, exp_r0, exp_r1, exp_v0, exp_v1);
    end
    if (exp_v0 || exp_v1) begin
      tests++;
      if ({RespResult, RespZero, RespNegative} !== {m_res, (m_res == '0), m_res[DW-1]}) begin
        fails++;
        $display("FAIL model_data t=%0t got %h z%b n%b want %h z%b n%b", $time,
                 RespResult, RespZero, RespNegative, m_res, (m_res == '0), m_res[DW-1]);
      end
    end
    if (lit_hs_en) begin
      tests++;
      if ({Req0Ready, Req1Ready, Resp0Valid, Resp1Valid} !== lit_hs) begin
        fails++;
        $display("FAIL lit_handshake t=%0t got %b%b%b%b want %b", $time,
                 Req0Ready, Req1Ready, Resp0Valid, Resp1Valid, lit_hs);
      end
    end
    if (lit_data_en) begin
      tests++;
      if ({RespResult, RespZero, RespNegative} !== {lit_res, lit_z, lit_n}) begin
        fails++;
        $display("FAIL lit_data t=%0t got %h z%b n%b want %h z%b n%b", $time,
                 RespResult, RespZero, RespNegative, lit_res, lit_z, lit_n);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    lit_hs_en = 1'b0; lit_data_en = 1'b0;
  endtask

  task automatic lit(input logic [3:0] hs);
    lit_hs_en = 1'b1; lit_hs = hs;
  endtask

  task automatic litd(input logic [DW-1:0] r, input logic z, input logic n);
    lit_data_en = 1'b1; lit_res = r; lit_z = z; lit_n = n;
  endtask

  task automatic r0(input logic v, input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    Req0Valid = v; Req0Control = c; Req0SrcA = a; Req0SrcB = b;
  endtask

  task automatic r1(input logic v, input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    Req1Valid = v; Req1Control = c; Req1SrcA = a; Req1SrcB = b;
  endtask

  logic [3:0]    f_op  [5] = '{4'd1, 4'd7, 4'd8, 4'd9, 4'hF};
  logic [DW-1:0] f_a   [5] = '{32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
  logic [DW-1:0] f_b   [5] = '{32'd3, 32'd4, 32'd1, 32'd1, 32'd6};
  logic [DW-1:0] f_res [5] = '{32'd0, 32'hF800_0000, 32'd1, 32'd0, 32'd0};
  logic          f_z   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic          f_n   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1;
    r0(1'b0, 4'd0, '0, '0); r1(1'b0, 4'd0, '0, '0);
    Resp0Ready = 1'b0; Resp1Ready = 1'b0;
    @(posedge clk); #1;

    // Reset held with a valid request: nothing may be accepted
    r0(1'b1, 4'd0, 32'd5, 32'd7); lit(4'b0000); tick();
    lit(4'b0000); tick();
    rst = 1'b0; r0(1'b0, 4'd0, '0, '0); lit(4'b0000); tick();

    // Single request ADD 5+7
    Resp0Ready = 1'b1; Resp1Ready = 1'b1;
    r0(1'b1, 4'd0, 32'd5, 32'd7); lit(4'b1000); tick();
    r0(1'b0, 4'd0, '0, '0); lit(4'b0010); litd(32'd12, 1'b0, 1'b0); tick();

    // Contention: port 0 served last, so port 1 wins the first tie
    for (int i = 0; i < 6; i++) begin
      r0(1'b1, 4'd0, DW'(i), 32'd100);
      r1(1'b1, 4'd4, DW'(i), 32'h0000_00FF);
      if (i == 0) lit(4'b0100);
      if (i == 1) begin lit(4'b1001); litd(32'h0000_00FF, 1'b0, 1'b0); end
      if (i == 2) begin lit(4'b0110); litd(32'd101, 1'b0, 1'b0); end
      tick();
    end
    r0(1'b0, 4'd0, '0, '0); r1(1'b0, 4'd0, '0, '0); tick();

    // Backpressure on port 1; Resp0Ready on the non-owner must be ignored
    Resp1Ready = 1'b0;
    r1(1'b1, 4'd1, 32'd0, 32'd1); lit(4'b0100); tick();
    r1(1'b0, 4'd0, '0, '0); r0(1'b1, 4'd0, 32'd9, 32'd1);
    for (int i = 0; i < 3; i++) begin
      lit(4'b0001); litd(32'hFFFF_FFFF, 1'b0, 1'b1); tick();
    end
    Resp1Ready = 1'b1; lit(4'b1001); litd(32'hFFFF_FFFF, 1'b0, 1'b1); tick();
    r0(1'b0, 4'd0, '0, '0); lit(4'b0010); litd(32'd10, 1'b0, 1'b0); tick();

    // Back-to-back flag/op checks on port 0
    for (int i = 0; i < 5; i++) begin
      r0(1'b1, f_op[i], f_a[i], f_b[i]);
      if (i == 0) lit(4'b1000);
      else begin lit(4'b1010); litd(f_res[i-1], f_z[i-1], f_n[i-1]); end
      tick();
    end
    r0(1'b0, 4'd0, '0, '0); lit(4'b0010); litd(f_res[4], f_z[4], f_n[4]); tick();

    // Reset while a result is held
    Resp0Ready = 1'b0;
    r0(1'b1, 4'd0, 32'd1, 32'd2); lit(4'b1000); tick();
    r0(1'b0, 4'd0, '0, '0); rst = 1'b1; lit(4'b0000); tick();
    rst = 1'b0; lit(4'b0000); tick();
    Resp0Ready = 1'b1;
    r0(1'b1, 4'd0, 32'd2, 32'd2); r1(1'b1, 4'd0, 32'd3, 32'd3); lit(4'b1000); tick();
    r0(1'b0, 4'd0, '0, '0); lit(4'b0110); litd(32'd4, 1'b0, 1'b0); tick();
    r1(1'b0, 4'd0, '0, '0); lit(4'b0001); litd(32'd6, 1'b0, 1'b0); tick();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
